// File: rtl/sound_pkg.sv
// Shared constants, types and the priority encoder for the sound event sequencer.
// Channel order in every vector is sheep, sword, player (index 0..2).
package sound_pkg;

  localparam int NUM_CH    = 3;
  localparam int CH_SHEEP  = 0;
  localparam int CH_SWORD  = 1;
  localparam int CH_PLAYER = 2;

  localparam int DEF_DUR_W      = 6;
  localparam int DEF_DUR_SHEEP  = 12;
  localparam int DEF_DUR_SWORD  = 6;
  localparam int DEF_DUR_PLAYER = 30;
  localparam int DEF_H_LAST     = 639;
  localparam int DEF_V_LAST     = 479;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PLAYING = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic sheep;
    logic sword;
    logic player;
    logic busy;
  } snd_out_t;

  // Fixed priority sheep > sword > player; masked channels keep running.
  function automatic snd_out_t arbitrate(input logic [NUM_CH-1:0] playing);
    snd_out_t o;
    o.sheep  = playing[CH_SHEEP];
    o.sword  = playing[CH_SWORD] & ~playing[CH_SHEEP];
    o.player = playing[CH_PLAYER] & ~playing[CH_SWORD] & ~playing[CH_SHEEP];
    o.busy   = |playing;
    return o;
  endfunction

endpackage

// File: rtl/sound_event_sequencer_if.sv
// Game-logic side of the sequencer: raw collision levels and pixel position in,
// one-hot APU sound requests out.
interface sound_event_sequencer_if;
  logic       sheep_dragon_hit;
  logic       sword_dragon_hit;
  logic       player_dragon_hit;
  logic [9:0] x;
  logic [9:0] y;
  logic       SheepDragonCollision;
  logic       SwordDragonCollision;
  logic       PlayerDragonCollision;
  logic       sound_busy;

  modport master (
    output sheep_dragon_hit, sword_dragon_hit, player_dragon_hit, x, y,
    input  SheepDragonCollision, SwordDragonCollision, PlayerDragonCollision, sound_busy
  );

  modport slave (
    input  sheep_dragon_hit, sword_dragon_hit, player_dragon_hit, x, y,
    output SheepDragonCollision, SwordDragonCollision, PlayerDragonCollision, sound_busy
  );
endinterface

// File: rtl/sound_channel_timer.sv
// One sound channel: rising-edge detect on the raw hit level, a frame-count-down
// burst timer and its IDLE/PLAYING state.
module sound_channel_timer
  import sound_pkg::*;
#(
  parameter int DUR_W = DEF_DUR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hit,
  input  logic             frame_tick,
  input  logic [DUR_W-1:0] duration,
  output logic             playing,
  output logic [DUR_W-1:0] count
);

  ch_state_e        state_q, state_d;
  logic [DUR_W-1:0] count_q, count_d;
  logic             hit_q, hit_d;
  logic             rise;

  assign rise = hit & ~hit_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hit_d   = hit;
    // A load beats a coincident tick so a fresh burst always starts at full length.
    if (rise && (duration != '0)) begin
      state_d = ST_PLAYING;
      count_d = duration;
    end else if ((state_q == ST_PLAYING) && frame_tick) begin
      if (count_q <= DUR_W'(1)) begin
        state_d = ST_IDLE;
        count_d = '0;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // The edge detector comes out of reset "already high", so a level held
  // across reset has to drop and rise again before it can trigger.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      hit_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hit_q   <= hit_d;
    end
  end

  assign playing = (state_q == ST_PLAYING);
  assign count   = count_q;

endmodule

// File: rtl/sound_event_sequencer.sv
// Turns raw collision levels into fixed-length, one-hot APU sound bursts timed
// in video frames; holds the frame-tick generator and the output arbiter.
module sound_event_sequencer
  import sound_pkg::*;
#(
  parameter int H_LAST     = DEF_H_LAST,
  parameter int V_LAST     = DEF_V_LAST,
  parameter int DUR_W      = DEF_DUR_W,
  parameter int DUR_SHEEP  = DEF_DUR_SHEEP,
  parameter int DUR_SWORD  = DEF_DUR_SWORD,
  parameter int DUR_PLAYER = DEF_DUR_PLAYER
) (
  input  logic                    clk,
  input  logic                    reset,
  sound_event_sequencer_if.slave  bus
);

  logic                          at_end, at_end_q, at_end_d;
  logic                          frame_tick;
  logic [NUM_CH-1:0]             hit;
  logic [NUM_CH-1:0]             playing;
  logic [NUM_CH-1:0]             live;
  logic [NUM_CH-1:0][DUR_W-1:0]  dur;
  logic [NUM_CH-1:0][DUR_W-1:0]  count;
  snd_out_t                      out_q, out_d;

  // One tick per frame no matter how many clocks the last pixel is held.
  assign at_end     = (bus.x == 10'(H_LAST)) && (bus.y == 10'(V_LAST));
  assign frame_tick = at_end & ~at_end_q;

  assign hit[CH_SHEEP]  = bus.sheep_dragon_hit;
  assign hit[CH_SWORD]  = bus.sword_dragon_hit;
  assign hit[CH_PLAYER] = bus.player_dragon_hit;

  assign dur[CH_SHEEP]  = DUR_W'(DUR_SHEEP);
  assign dur[CH_SWORD]  = DUR_W'(DUR_SWORD);
  assign dur[CH_PLAYER] = DUR_W'(DUR_PLAYER);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sound_channel_timer #(.DUR_W(DUR_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .hit        (hit[c]),
      .frame_tick (frame_tick),
      .duration   (dur[c]),
      .playing    (playing[c]),
      .count      (count[c])
    );
    assign live[c] = playing[c] & (count[c] != '0);
  end

  always_comb begin
    at_end_d = at_end;
    out_d    = arbitrate(live);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      at_end_q <= 1'b0;
      out_q    <= '0;
    end else begin
      at_end_q <= at_end_d;
      out_q    <= out_d;
    end
  end

  assign bus.SheepDragonCollision  = out_q.sheep;
  assign bus.SwordDragonCollision  = out_q.sword;
  assign bus.PlayerDragonCollision = out_q.player;
  assign bus.sound_busy            = out_q.busy;

endmodule

// File: tb/tb_sound_event_sequencer.sv
// Directed bench for sound_event_sequencer: a vector table for reset/idle/sword
// burst, then hand-written sequences for held levels, preemption and reset.
module tb_sound_event_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sound_event_sequencer_if bus();

  sound_event_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {sheep, sword, player, busy}
  logic [3:0] outs;
  assign outs = {bus.SheepDragonCollision, bus.SwordDragonCollision,
                 bus.PlayerDragonCollision, bus.sound_busy};

  typedef struct {
    logic       rst_n;
    logic [2:0] hit;     // {sheep, sword, player}
    logic       at_end;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   viol  = 0;
  int   hi;

  task automatic step();
    @(posedge clk);
    #1;
    if ((outs[3] + outs[2] + outs[1]) > 1) viol++;
  endtask

  task automatic check(input string name, input logic [3:0] exp);
    n_cmp++;
    if (outs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, outs, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic set_end(input logic e);
    bus.x = e ? 10'd639 : 10'd0;
    bus.y = e ? 10'd479 : 10'd0;
  endtask

  task automatic frame();
    set_end(1'b1);
    step();
    set_end(1'b0);
    step();
    step();
  endtask

  task automatic run_count(input int n, input int idx, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      frame();
      if (outs[idx]) cnt++;
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [2:0] h, input logic e,
                              input logic [3:0] x);
    vec_t v;
    v.rst_n = r; v.hit = h; v.at_end = e; v.exp = x;
    return v;
  endfunction

  initial begin
    reset = 1'b0;
    bus.sheep_dragon_hit  = 1'b0;
    bus.sword_dragon_hit  = 1'b0;
    bus.player_dragon_hit = 1'b0;
    set_end(1'b0);

    // reset, idle frames, then a one-clock sword pulse playing for 6 ticks
    tbl.push_back(mk(1'b0, 3'b000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b0, 3'b000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 4'b0000));
    for (int f = 0; f < 3; f++) begin
      tbl.push_back(mk(1'b1, 3'b000, 1'b1, 4'b0000));
      tbl.push_back(mk(1'b1, 3'b000, 1'b0, 4'b0000));
      tbl.push_back(mk(1'b1, 3'b000, 1'b0, 4'b0000));
    end
    tbl.push_back(mk(1'b1, 3'b010, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 4'b0101));
    for (int t = 1; t <= 5; t++) begin
      for (int k = 0; k < ((t == 3) ? 3 : 1); k++)
        tbl.push_back(mk(1'b1, 3'b000, 1'b1, 4'b0101));
      tbl.push_back(mk(1'b1, 3'b000, 1'b0, 4'b0101));
    end
    tbl.push_back(mk(1'b1, 3'b000, 1'b1, 4'b0101));
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 4'b0000));
    tbl.push_back(mk(1'b1, 3'b000, 1'b0, 4'b0000));

    for (int i = 0; i < tbl.size(); i++) begin
      reset                 = tbl[i].rst_n;
      bus.sheep_dragon_hit  = tbl[i].hit[2];
      bus.sword_dragon_hit  = tbl[i].hit[1];
      bus.player_dragon_hit = tbl[i].hit[0];
      set_end(tbl[i].at_end);
      step();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    set_end(1'b0);

    // reset mid-burst with the sword counter at 4, level held across reset
    bus.sword_dragon_hit = 1'b1;
    step(); step();
    check("rst_burst_on", 4'b0101);
    frame(); frame();
    reset = 1'b0;
    step();
    check("rst_mid", 4'b0000);
    reset = 1'b1;
    step(); step();
    check("rst_held_no_retrig", 4'b0000);
    frame();
    check("rst_held_frame", 4'b0000);
    bus.sword_dragon_hit = 1'b0;
    step();
    bus.sword_dragon_hit = 1'b1;
    step();
    check("rst_toggle_lat1", 4'b0000);
    step();
    check("rst_toggle_on", 4'b0101);
    bus.sword_dragon_hit = 1'b0;
    for (int i = 0; i < 6; i++) frame();
    check("rst_toggle_end", 4'b0000);

    // player level held for 100 frames: one burst only
    bus.player_dragon_hit = 1'b1;
    step();
    check("player_lat1", 4'b0000);
    step();
    check("player_lat2", 4'b0011);
    run_count(100, 1, hi);
    check_int("player_held_frames", hi, 29);
    bus.player_dragon_hit = 1'b0;
    step();
    bus.player_dragon_hit = 1'b1;
    step(); step();
    check("player_retrig", 4'b0011);
    run_count(30, 1, hi);
    check_int("player_retrig_frames", hi, 29);
    check("player_end", 4'b0000);

    // rise on the same clock as a frame tick: full-length load
    bus.player_dragon_hit = 1'b0;
    step();
    bus.player_dragon_hit = 1'b1;
    set_end(1'b1);
    step();
    set_end(1'b0);
    step(); step();
    check("coinc_start", 4'b0011);
    run_count(30, 1, hi);
    check_int("coinc_frames", hi, 29);
    bus.player_dragon_hit = 1'b0;
    step();

    // player preempted by sheep after 5 frames, then resumes
    viol = 0;
    bus.player_dragon_hit = 1'b1;
    step(); step();
    check("pre_player_on", 4'b0011);
    bus.player_dragon_hit = 1'b0;
    for (int i = 0; i < 5; i++) frame();
    bus.sheep_dragon_hit = 1'b1;
    step();
    check("pre_sheep_lat1", 4'b0011);
    bus.sheep_dragon_hit = 1'b0;
    step();
    check("pre_sheep_on", 4'b1001);
    for (int k = 1; k <= 25; k++) begin
      frame();
      check($sformatf("pre_frame%0d", k),
            (k < 12) ? 4'b1001 : ((k < 25) ? 4'b0011 : 4'b0000));
    end
    check_int("pre_onehot_viol", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
